nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

- Multi-cycle wide adder built on one `adder_4bit` instance.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Sequences the operands nibble by nibble, LSB first, through the 4-bit adder, with a registered carry between nibbles.
- Returns the WIDTH-bit sum, carry-out and signed overflow over a second valid/ready handshake.
- Sits upstream of `adder_4bit` as its operand feeder and downstream as its result collector; trades latency for one 4-bit adder's area.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of 4 and ≥ 8, otherwise elaboration error.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, cin valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into nibble 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow.

## Operation
- NIB = WIDTH/4.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch a and b into shift registers and cin into the carry register.
  - Latch a[WIDTH-1] and b[WIDTH-1] separately.
  - Clear the nibble counter; go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, present the low nibble of each shift register plus the carry register to `adder_4bit`.
  - Shift the 4-bit sum into the result register from the top, so it ends LSB-aligned after NIB shifts.
  - Load the carry register with the adder's carry-out.
  - Shift both operand registers right by 4; increment the counter.
  - Leave for DONE on the edge that processes nibble NIB-1.
- DONE:
  - out_valid = 1.
  - sum = result register; cout = carry register.
  - ovf = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb).
  - sum, cout and ovf hold stable while out_ready = 0.
  - On out_valid && out_ready, go to IDLE.
- No overlap: operands are never accepted while an operation is in RUN or DONE. in_valid outside IDLE is ignored; upstream holds its data.
- sum, cout and ovf are registered and retain their last values in IDLE. They are qualified only by out_valid.
- Reset values: state IDLE, in_ready 0 while rst is high, out_valid 0, sum 0, cout 0, ovf 0, counter 0, carry 0.
- Reset mid-RUN or mid-DONE aborts the operation and discards the partial result. The cycle after rst deasserts: IDLE, in_ready 1.
- Simultaneous in_valid and rst: reset wins, operands not accepted.

## Timing
- Accept edge E0 enters RUN.
- Nibble k is processed on edge E0+1+k.
- out_valid rises after edge E0+NIB, i.e. NIB cycles after acceptance (4 for WIDTH=16).
- Earliest result transfer is edge E0+NIB+1; in_ready rises the following cycle.
- Minimum initiation interval is NIB+2 cycles (6 for WIDTH=16).
- The combinational path is one 4-bit ripple plus register setup, independent of WIDTH.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to either.

## Structure
- Shared package `nibble_adder_pkg`:
  - FSM state typedef (IDLE/RUN/DONE).
  - Constant NIBBLE_W = 4.
  - Function computing NIB and the counter width, $clog2(NIB).
- Exactly one sub-module: a single `adder_4bit` instance. No other arithmetic in this block except the ovf compare.

## Test plan
- a=0x1234, b=0x4321, cin=0, out_ready=1 → out_valid exactly 4 cycles after accept; sum=0x5555, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0; carry propagates through all 4 nibbles.
- a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000, cin=0 → sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1, a=0x0001 → sum, cout, ovf and out_valid stable; in_ready=0; new operands not taken until after the result transfer.
- Assert rst for 1 cycle after 2 nibbles of a=0xAAAA + b=0x5555 → next cycle out_valid=0, sum=0, in_ready=1. Then a=0x0008, b=0x0008, cin=0 → sum=0x0010, cout=0.
- Back-to-back: in_valid and out_ready held at 1 with 3 distinct operand pairs → accepts spaced exactly 6 cycles; results match a+b+cin in order.

Source files
------------

// File: rtl/nibble_adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
package nibble_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width / NIBBLE_W);
  endfunction

endpackage

// File: rtl/adder_4bit.sv
// 4-bit ripple adder; the only wide arithmetic resource of the serial adder.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that streams operands LSB-first through one 4-bit adder,
// with valid/ready handshakes on both the operand and the result side.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int             NIB  = nib_count(WIDTH);
  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic             carry, a_msb, b_msb, cout_q, ovf_q;
  logic [CW-1:0]    cnt;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             accept;

  assign accept = in_valid && in_ready;

  adder_4bit u_adder (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: a default assignment ahead of the case keeps this block free of latches.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept)      next_state = RUN;
      RUN:     if (cnt == LAST) next_state = DONE;
      DONE:    if (out_ready)   next_state = IDLE;
      default:                  next_state = IDLE;
    endcase
  end

  // Handshake outputs depend only on registered state (and reset masking in_ready).
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready  = !rst;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> NIBBLE_W;
      b_sh  <= b_sh >> NIBBLE_W;
      // New nibble enters at the top so the word is LSB-aligned after NIB shifts.
      res   <= {nib_sum, res[WIDTH-1:NIBBLE_W]};
      carry <= nib_cout;
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) begin
        cout_q <= nib_cout;
        ovf_q  <= (a_msb == b_msb) && (nib_sum[NIBBLE_W-1] != a_msb);
      end
    end
  end

  assign sum  = res;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench: expected results are queued at operand acceptance and
// compared when the adder hands a result over.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  exp_t q[$];
  exp_t mon_e;
  exp_t hold_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_edge = 0;
  int   b2b_last = -1;
  bit   b2b = 1'b0;
  logic prev_ov = 1'b0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c);
    exp_t         r;
    logic [WIDTH:0] t;
    t    = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    r.s  = t[WIDTH-1:0];
    r.co = t[WIDTH];
    r.ov = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    return r;
  endfunction

  // Monitor: samples on the falling edge, between driver updates and DUT edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        check("accept_while_busy", q.size(), 0);
        q.push_back(model(a, b, cin));
        acc_edge = cyc + 1;
        if (b2b) begin
          if (b2b_last >= 0) check("b2b_interval", acc_edge - b2b_last, NIB + 2);
          b2b_last = acc_edge;
        end
      end
      if (out_valid && !prev_ov) check("latency", cyc - acc_edge, NIB);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          mon_e = q.pop_front();
          check("sum", sum, mon_e.s);
          check("cout", cout, mon_e.co);
          check("ovf", ovf, mon_e.ov);
        end
      end
    end
    prev_ov = out_valid;
  end

  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    bit got = 1'b0;
    in_valid = 1'b1;
    a   = x;
    b   = y;
    cin = c;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else begin
      check("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0 && in_ready && !out_valid) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) ok = 1'b1;
    end
    if (!ok) check("valid_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 1);

    do_op(16'h1234, 16'h4321, 1'b0); wait_idle();
    do_op(16'hFFFF, 16'h0001, 1'b0); wait_idle();
    do_op(16'h7FFF, 16'h0000, 1'b1); wait_idle();
    do_op(16'h8000, 16'h8000, 1'b0); wait_idle();

    // Backpressure: result must hold while new operands wait upstream.
    out_ready = 1'b0;
    do_op(16'h0F0F, 16'h1111, 1'b1);
    wait_valid();
    in_valid = 1'b1;
    a   = 16'h0001;
    b   = 16'h0002;
    cin = 1'b0;
    hold_e = q[0];
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sum", sum, hold_e.s);
      check("bp_cout", cout, hold_e.co);
      check("bp_ovf", ovf, hold_e.ov);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    do_op(16'h0001, 16'h0002, 1'b0); wait_idle();

    // Reset after two nibbles aborts the operation.
    do_op(16'hAAAA, 16'h5555, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_in_ready", in_ready, 1);
    do_op(16'h0008, 16'h0008, 1'b0); wait_idle();

    // Back-to-back with out_ready held high.
    b2b = 1'b1;
    b2b_last = -1;
    do_op(16'h0123, 16'h0FED, 1'b1);
    do_op(16'hC000, 16'hC001, 1'b0);
    do_op(16'h5A5A, 16'h2525, 1'b1);
    wait_idle();
    b2b = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
